// File: rtl/tune_player.sv
// ============================================================================
// Module  : tune_player
// Purpose : Plays stored note sequences as a square wave on a buzzer output.
//           Optional macro TUNE_PLAYER_LOOP_EN adds a loop-playback input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tune_player #(
  parameter int NOTE_W   = 32,
  parameter int TUNE_CNT = 4,
  parameter int TUNE_MAX = 8,
  parameter int GAP_CYC  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(TUNE_CNT)-1:0] wr_tune,
  input  logic [$clog2(TUNE_MAX)-1:0] wr_idx,
  input  logic [NOTE_W-1:0]           wr_period,
  input  logic [NOTE_W-1:0]           wr_duration,
  input  logic                        wr_last,
  input  logic                        play_req,
  input  logic [$clog2(TUNE_CNT)-1:0] play_tune,
  input  logic                        stop,
`ifdef TUNE_PLAYER_LOOP_EN
  input  logic                        loop,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(TUNE_MAX)-1:0] note_idx,
  output logic                        buzzer_out
);

  localparam int TW = $clog2(TUNE_CNT);
  localparam int IW = $clog2(TUNE_MAX);
  localparam int EW = 2 * NOTE_W + 1;
  localparam logic [IW-1:0]     c_IDX_LAST = IW'(TUNE_MAX - 1);
  localparam logic [NOTE_W-1:0] c_GAP_LAST = (GAP_CYC > 0) ? NOTE_W'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_tune;
  logic [IW-1:0]     r_idx;
  logic [NOTE_W-1:0] r_period;
  logic [NOTE_W-1:0] r_dur;
  logic              r_last;
  logic [NOTE_W-1:0] r_cnt;
  logic [NOTE_W-1:0] r_phase;
  logic              r_done;
  logic              r_buzz;
  logic [EW-1:0]     r_mem [TUNE_CNT*TUNE_MAX];

  logic [EW-1:0]     w_rd;
  logic [NOTE_W-1:0] w_rd_period;
  logic [NOTE_W-1:0] w_rd_dur;
  logic              w_rd_last;
  logic [NOTE_W-1:0] w_dur_last;
  logic              w_play_end;
  logic              w_gap_end;
  logic              w_note_over;
  logic              w_last_note;
  logic              w_loop_on;
  logic              w_tone;
  logic [NOTE_W-1:0] w_half;
  logic              w_ph_wrap;
  logic [NOTE_W-1:0] w_ph_next;

  // Tune memory: write port is independent of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[{wr_tune, wr_idx}] <= {wr_last, wr_duration, wr_period};
    end
  end

  // Asynchronous read: a same-cycle write lands after LOAD has sampled.
  assign w_rd        = r_mem[{r_tune, r_idx}];
  assign w_rd_period = w_rd[NOTE_W-1:0];
  assign w_rd_dur    = w_rd[2*NOTE_W-1:NOTE_W];
  assign w_rd_last   = w_rd[EW-1];

  assign w_dur_last  = (r_dur == '0) ? '0 : (r_dur - 1'b1);
  assign w_play_end  = (r_state == S_PLAY) && (r_cnt == w_dur_last);
  assign w_gap_end   = (r_state == S_GAP) && (r_cnt == c_GAP_LAST);
  assign w_note_over = w_gap_end || (w_play_end && (GAP_CYC == 0));
  assign w_last_note = r_last || (r_idx == c_IDX_LAST);

  assign w_tone      = |r_period[NOTE_W-1:1];
  assign w_half      = r_period >> 1;
  assign w_ph_wrap   = (r_phase == (r_period - 1'b1));
  assign w_ph_next   = w_ph_wrap ? '0 : (r_phase + 1'b1);

`ifdef TUNE_PLAYER_LOOP_EN
  logic r_loop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_loop <= 1'b0;
    end else if (!stop && play_req) begin
      r_loop <= loop;
    end
  end

  assign w_loop_on = r_loop;
`else
  assign w_loop_on = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_tune   <= '0;
      r_idx    <= '0;
      r_period <= '0;
      r_dur    <= '0;
      r_last   <= 1'b0;
      r_cnt    <= '0;
      r_phase  <= '0;
      r_done   <= 1'b0;
      r_buzz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_buzz <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_phase <= '0;
      end else if (play_req) begin
        r_state <= S_LOAD;
        r_tune  <= play_tune;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_phase <= '0;
      end else if (w_note_over) begin
        r_cnt <= '0;
        if (w_last_note && !w_loop_on) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_LOAD;
          r_idx   <= w_last_note ? '0 : (r_idx + 1'b1);
        end
      end else begin
        case (r_state)
          S_LOAD: begin
            r_period <= w_rd_period;
            r_dur    <= w_rd_dur;
            r_last   <= w_rd_last;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_buzz   <= |w_rd_period[NOTE_W-1:1];
            r_state  <= S_PLAY;
          end
          S_PLAY: begin
            if (w_play_end) begin
              r_state <= S_GAP;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_phase <= w_ph_next;
              r_buzz  <= w_tone && (w_ph_next < w_half);
            end
          end
          S_GAP: begin
            r_cnt <= r_cnt + 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign note_idx   = r_idx;
  assign buzzer_out = r_buzz;

endmodule

`default_nettype wire

// File: tb/tb_tune_player.sv
// ============================================================================
// Module  : tb_tune_player
// Purpose : Self-checking bench for tune_player (table, directed, random).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tune_player;

  localparam int NW  = 16;
  localparam int TC  = 4;
  localparam int TM  = 4;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, wr_last, play_req, stop;
  logic [1:0]    wr_tune, wr_idx, play_tune;
  logic [NW-1:0] wr_period, wr_duration;
  logic          busy, done, buzzer_out;
  logic [1:0]    note_idx;
`ifdef TUNE_PLAYER_LOOP_EN
  logic          loop;
`endif

  always #5 clk = ~clk;

  tune_player #(.NOTE_W(NW), .TUNE_CNT(TC), .TUNE_MAX(TM), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_tune(wr_tune), .wr_idx(wr_idx),
    .wr_period(wr_period), .wr_duration(wr_duration), .wr_last(wr_last),
    .play_req(play_req), .play_tune(play_tune), .stop(stop),
`ifdef TUNE_PLAYER_LOOP_EN
    .loop(loop),
`endif
    .busy(busy), .done(done), .note_idx(note_idx), .buzzer_out(buzzer_out)
  );

  // Reference model: a note is a segment of 1 fetch + max(D,1) tone + GAP silent cycles.
  int mem_p [TC][TM];
  int mem_d [TC][TM];
  bit mem_l [TC][TM];
  bit m_busy, m_done, m_loop, m_last;
  int m_tune, m_idx, m_t, m_p, m_d;

  int n_vec, n_err;
  int n_done, n_hi, idx_mask, n_busy;

  typedef struct {
    bit       req;
    bit       busy;
    bit       done;
    bit [1:0] idx;
    bit       buzz;
  } vec_t;
  vec_t tbl [20];

  function automatic bit m_buzz();
    int dm;
    dm = (m_d < 1) ? 1 : m_d;
    if (!m_busy || m_t < 1 || m_t > dm || m_p < 2) return 1'b0;
    return ((m_t - 1) % m_p) < (m_p / 2);
  endfunction

  task automatic model_step();
    int dm;
    bit lp;
    lp = 1'b0;
`ifdef TUNE_PLAYER_LOOP_EN
    lp = loop;
`endif
    m_done = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_t = 0; m_loop = 0; m_p = 0; m_d = 0;
    end else if (stop) begin
      m_busy = 0;
    end else if (play_req) begin
      m_busy = 1; m_tune = int'(play_tune); m_idx = 0; m_t = 0; m_loop = lp;
    end else if (m_busy) begin
      if (m_t == 0) begin
        m_p = mem_p[m_tune][m_idx]; m_d = mem_d[m_tune][m_idx]; m_last = mem_l[m_tune][m_idx];
      end
      dm = (m_d < 1) ? 1 : m_d;
      m_t++;
      if (m_t == 1 + dm + GAP) begin
        m_t = 0;
        if (m_last || m_idx == TM - 1) begin
          if (m_loop) m_idx = 0;
          else begin m_busy = 0; m_done = 1; end
        end else begin
          m_idx++;
        end
      end
    end
    if (wr_en) begin
      mem_p[wr_tune][wr_idx] = int'(wr_period);
      mem_d[wr_tune][wr_idx] = int'(wr_duration);
      mem_l[wr_tune][wr_idx] = wr_last;
    end
  endtask

  task automatic cyc(string name);
    logic [4:0] exp, act;
    @(posedge clk);
    model_step();
    #1;
    exp = {m_busy, m_done, 2'(m_idx), m_buzz()};
    act = {busy, done, note_idx, buzzer_out};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: busy/done/idx/buzz got %b required %b", name, $time, act, exp);
    end
    if (done === 1'b1) n_done++;
    if (buzzer_out === 1'b1) n_hi++;
    if (busy === 1'b1) begin n_busy++; idx_mask |= (1 << note_idx); end
  endtask

  task automatic expect_eq(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clr_stats();
    n_done = 0; n_hi = 0; idx_mask = 0; n_busy = 0;
  endtask

  task automatic wr(int t, int i, int p, int d, bit l);
    wr_en = 1'b1; wr_tune = 2'(t); wr_idx = 2'(i);
    wr_period = NW'(p); wr_duration = NW'(d); wr_last = l;
    cyc("write");
    wr_en = 1'b0;
  endtask

  task automatic play(int t);
    play_req = 1'b1; play_tune = 2'(t);
    cyc("play");
    play_req = 1'b0;
  endtask

  task automatic run_until_idle(string name, int budget);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin cyc(name); k++; end
    if (busy === 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic run_table(string name);
    logic [4:0] exp, act;
    for (int k = 0; k < 20; k++) begin
      play_req = tbl[k].req; play_tune = 2'd1;
      cyc(name);
      exp = {tbl[k].busy, tbl[k].done, tbl[k].idx, tbl[k].buzz};
      act = {busy, done, note_idx, buzzer_out};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s row %0d: busy/done/idx/buzz got %b required %b", name, k, act, exp);
      end
    end
    play_req = 1'b0;
  endtask

  initial begin
    bit [19:0] p_busy, p_done, p_idx1, p_buzz;
    int waits, wraps;
    logic [1:0] prev_idx;

    // Rows: outputs after edge k+1 following a play_req of tune 1.
    p_busy = 20'b1111_1111_1111_1111_1000;
    p_done = 20'b0000_0000_0000_0000_0100;
    p_idx1 = 20'b0000_0000_0001_1111_1111;
    p_buzz = 20'b0110_0110_0000_0000_0000;
    for (int k = 0; k < 20; k++) begin
      tbl[k].req  = (k == 0);
      tbl[k].busy = p_busy[19-k];
      tbl[k].done = p_done[19-k];
      tbl[k].idx  = {1'b0, p_idx1[19-k]};
      tbl[k].buzz = p_buzz[19-k];
    end

    n_vec = 0; n_err = 0;
    m_busy = 0; m_done = 0; m_loop = 0; m_last = 0;
    m_tune = 0; m_idx = 0; m_t = 0; m_p = 0; m_d = 0;
    clr_stats();
    rst_n = 1'b0; wr_en = 1'b0; wr_last = 1'b0; play_req = 1'b0; stop = 1'b0;
    wr_tune = '0; wr_idx = '0; play_tune = '0; wr_period = '0; wr_duration = '0;
`ifdef TUNE_PLAYER_LOOP_EN
    loop = 1'b0;
`endif

    repeat (3) cyc("reset");
    expect_eq("reset_outputs", int'({busy, done, note_idx, buzzer_out}), 0);
    rst_n = 1'b1;

    for (int t = 0; t < TC; t++)
      for (int i = 0; i < TM; i++)
        wr(t, i, $urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 1));
    wr(0, 0, 3, 5, 0); wr(0, 1, 1, 2, 0); wr(0, 2, 2, 0, 0); wr(0, 3, 0, 1, 0);
    wr(1, 0, 4, 8, 0); wr(1, 1, 0, 3, 1);
    wr(2, 0, 6, 12, 0); wr(2, 1, 2, 4, 1);
    repeat (2) cyc("idle");

    // Basic tune waveform from the table.
    clr_stats();
    run_table("tune1_table");
    expect_eq("tune1_done_count", n_done, 1);

    // Four-note tune without any last flag ends after note 3.
    clr_stats();
    play(0);
    run_until_idle("tune0", 200);
    repeat (2) cyc("tune0_tail");
    expect_eq("tune0_notes_seen", idx_mask, 15);
    expect_eq("tune0_busy_cycles", n_busy, 21);
    expect_eq("tune0_done_count", n_done, 1);

    // Preemption of tune 1 during note 1 by tune 2.
    play(1);
    waits = 0;
    while (!(m_busy && m_idx == 1 && m_t == 2) && waits < 50) begin cyc("pre_wait"); waits++; end
    expect_eq("pre_reached_note1", waits < 50 ? 1 : 0, 1);
    clr_stats();
    play(2);
    expect_eq("pre_idx_reset", int'(note_idx), 0);
    repeat (12) cyc("pre_tune2");
    expect_eq("pre_no_done", n_done, 0);
    expect_eq("pre_tune2_highs", n_hi, 6);
    run_until_idle("pre_finish", 100);

    // stop wins over play_req in the same cycle.
    play(0);
    repeat (6) cyc("stop_run");
    clr_stats();
    stop = 1'b1; play_req = 1'b1; play_tune = 2'd3;
    cyc("stop_same");
    stop = 1'b0; play_req = 1'b0;
    expect_eq("stop_busy", int'(busy), 0);
    expect_eq("stop_buzz", int'(buzzer_out), 0);
    repeat (5) cyc("stop_after");
    expect_eq("stop_no_done", n_done, 0);

    // Write to the entry being fetched in LOAD: old contents are played.
    play(1);
    clr_stats();
    wr(1, 0, 0, 8, 0);
    repeat (8) cyc("collide_play");
    expect_eq("collide_old_highs", n_hi, 4);
    run_until_idle("collide_finish", 100);
    clr_stats();
    play(1);
    run_until_idle("newdata", 100);
    expect_eq("newdata_highs", n_hi, 0);
    wr(1, 0, 4, 8, 0);

    // Reset mid-PLAY, then identical replay from retained memory.
    play(1);
    repeat (4) cyc("rst_run");
    rst_n = 1'b0;
    cyc("rst_mid");
    expect_eq("rst_mid_outputs", int'({busy, done, note_idx, buzzer_out}), 0);
    rst_n = 1'b1;
    cyc("rst_idle");
    clr_stats();
    run_table("replay_table");
    expect_eq("replay_done_count", n_done, 1);

`ifdef TUNE_PLAYER_LOOP_EN
    // Looping a two-note tune until stop.
    clr_stats();
    loop = 1'b1;
    play(1);
    loop = 1'b0;
    wraps = 0;
    prev_idx = note_idx;
    for (int k = 0; k < 60; k++) begin
      cyc("loop_run");
      if (prev_idx == 2'd1 && note_idx == 2'd0) wraps++;
      prev_idx = note_idx;
    end
    expect_eq("loop_no_done", n_done, 0);
    expect_eq("loop_wraps", wraps, 3);
    stop = 1'b1;
    cyc("loop_stop");
    stop = 1'b0;
    expect_eq("loop_stopped", int'(busy), 0);
`else
    wraps = 0; prev_idx = '0;
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      rst_n       = ($urandom_range(0, 399) != 0);
      stop        = ($urandom_range(0, 59) == 0);
      play_req    = ($urandom_range(0, 24) == 0);
      play_tune   = 2'($urandom_range(0, 3));
      wr_en       = rst_n && ($urandom_range(0, 9) == 0);
      wr_tune     = 2'($urandom_range(0, 3));
      wr_idx      = 2'($urandom_range(0, 3));
      wr_period   = NW'($urandom_range(0, 7));
      wr_duration = NW'($urandom_range(0, 9));
      wr_last     = 1'($urandom_range(0, 1));
`ifdef TUNE_PLAYER_LOOP_EN
      loop        = 1'($urandom_range(0, 1));
`endif
      cyc("random");
    end
    rst_n = 1'b1; stop = 1'b0; play_req = 1'b0; wr_en = 1'b0;
    cyc("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
